// File: rtl/lab2_t2.sv
// 1-bit full-adder cell: x = sum, y = carry-out.
module lab2_t2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x,
    output logic y
);

    // Sum and carry of three input bits
    assign x = a ^ b ^ c;
    assign y = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: streams captured operands LSB-first through
// a single full-adder cell, one bit per clock, and reports sum/carry-out
// with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cell_x;
    logic             cell_y;
    logic             last_c;

    // Single full-adder cell fed from the operand LSBs and the carry register
    lab2_t2 u_fa (
        .a (a_q[0]),
        .b (b_q[0]),
        .c (carry_q),
        .x (cell_x),
        .y (cell_y)
    );

    // Sum shift register next value: new bit enters at the MSB
    generate
        if (WIDTH == 1) begin : g_s_one
            assign s_d = cell_x;
        end else begin : g_s_wide
            assign s_d = {cell_x, s_q[WIDTH-1:1]};
        end
    endgenerate

    // Final bit of the current operation
    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    carry_q <= cell_y;
                    s_q     <= s_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        state_q <= DONE;
                        sum_q   <= s_d;
                        cout_q  <= cell_y;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    if (start) begin
                        state_q <= RUN;
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= cin;
                        s_q     <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Status decoded from the state register; results come from registers
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign sum_out = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum_out;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_adder_ctrl #(.WIDTH(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .a_in    (a1),
        .b_in    (b1),
        .cin     (cin1),
        .busy    (busy1),
        .done    (done1),
        .sum_out (sum1),
        .cout    (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain arithmetic sum with carry-out in bit 8
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        return 9'(a) + 9'(b) + 9'(c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the first negedge in RUN
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; counts cycles and busy cycles seen
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 30) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Count done pulses over n cycles
    task automatic count_done(input int n, output int dcnt);
        dcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
    endtask

    // Full single operation with latency and result checks
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
        int lat;
        int bcnt;
        logic [8:0] exp;
        exp = ref8(a, b, c);
        start_op(a, b, c);
        wait_done(lat, bcnt);
        chk({tag, "_lat"}, 32'(lat), 32'd8);
        chk({tag, "_busy"}, 32'(bcnt), 32'd8);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_res"}, 32'({cout, sum_out}), 32'(exp));
    endtask

    logic [7:0] a5 [6];
    logic [7:0] b5 [6];
    logic       c5 [6];

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        int prev;
        logic [8:0] exp;
        logic [1:0] exp1;

        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'({cout, sum_out}), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sums with known results
        run_op("t1", 8'h35, 8'h4A, 1'b0);
        chk("t1_const", 32'({cout, sum_out}), 32'h07F);
        @(negedge clk);
        chk("t1_pulse", 32'(done), 32'd0);
        chk("t1_hold", 32'({cout, sum_out}), 32'h07F);

        run_op("t2a", 8'hFF, 8'h01, 1'b0);
        chk("t2a_const", 32'({cout, sum_out}), 32'h100);
        run_op("t2b", 8'hFF, 8'hFF, 1'b1);
        chk("t2b_const", 32'({cout, sum_out}), 32'h1FF);
        @(negedge clk);

        // Start during RUN is ignored
        start_op(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        start_op(8'hAA, 8'h55, 1'b1);
        chk("t3_stable", 32'({cout, sum_out}), 32'h1FF);
        wait_done(lat, bcnt);
        chk("t3_lat", 32'(lat), 32'd5);
        chk("t3_res", 32'({cout, sum_out}), 32'h030);
        count_done(15, dcnt);
        chk("t3_single", 32'(dcnt), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN
        start_op(8'hC3, 8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_res", 32'({cout, sum_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(15, dcnt);
        chk("t4_nodone", 32'(dcnt), 32'd0);
        chk("t4_res2", 32'({cout, sum_out}), 32'd0);
        run_op("t4_after", 8'hC3, 8'h5A, 1'b1);
        @(negedge clk);

        // Random single operations
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
        end

        // Back-to-back with start held high
        for (int i = 0; i < 6; i++) begin
            a5[i] = 8'($urandom);
            b5[i] = 8'($urandom);
            c5[i] = 1'($urandom);
        end
        start = 1'b1;
        a_in  = a5[0];
        b_in  = b5[0];
        cin   = c5[0];
        @(negedge clk);
        a_in  = a5[1];
        b_in  = b5[1];
        cin   = c5[1];
        prev  = 0;
        for (int i = 0; i < 6; i++) begin
            lat = 0;
            while (!done && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            exp = ref8(a5[i], b5[i], c5[i]);
            chk($sformatf("t5_done%0d", i), 32'(done), 32'd1);
            chk($sformatf("t5_res%0d", i), 32'({cout, sum_out}), 32'(exp));
            if (i > 0) chk($sformatf("t5_gap%0d", i), 32'(cyc - prev), 32'd9);
            prev = cyc;
            @(negedge clk);
            if (i + 2 < 6) begin
                a_in = a5[i+2];
                b_in = b5[i+2];
                cin  = c5[i+2];
            end else begin
                start = 1'b0;
            end
        end
        count_done(12, dcnt);
        chk("t5_end", 32'(dcnt), 32'd0);

        // WIDTH=1 build: every input combination
        for (int k = 0; k < 8; k++) begin
            start1 = 1'b1;
            a1     = 1'((k >> 2) & 1);
            b1     = 1'((k >> 1) & 1);
            cin1   = 1'(k & 1);
            exp1   = 2'((k >> 2) & 1) + 2'((k >> 1) & 1) + 2'(k & 1);
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("w1_busy%0d", k), 32'(busy1), 32'd1);
            lat = 0;
            while (!done1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("w1_lat%0d", k), 32'(lat), 32'd1);
            chk($sformatf("w1_res%0d", k), 32'({cout1, sum1}), 32'(exp1));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
